pipelined_addsub: RTL and testbench

PIPELINED_ADDSUB -- requirements
Module: pipelined_addsub

---
 rtl/addsub_pkg.sv | 21 ++
 rtl/addsub_segment.sv | 16 +
 rtl/pipelined_addsub.sv | 114 +++++++++++
 tb/tb_pipelined_addsub.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: stage-register bundle and segment sizing shared by
// pipelined_addsub and its per-stage segment adders.
package addsub_pkg;

  localparam int ADDSUB_MAX_W = 128;

  typedef struct packed {
    logic                    valid;
    logic                    carry;
    logic                    sub;
    logic                    sat;
    logic [ADDSUB_MAX_W-1:0] a;
    logic [ADDSUB_MAX_W-1:0] b;
    logic [ADDSUB_MAX_W-1:0] r;
  } stage_t;

  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// addsub_segment: one SEG-bit slice of the ripple, carry in to carry out.
module addsub_segment
  import addsub_pkg::*;
#(
  parameter int SEG = 16
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + (SEG+1)'(cin);

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: STAGES-deep segmented ripple add/sub with handshake.
// Optional saturation on signed overflow when ADDSUB_SAT_EN is defined.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
`ifdef ADDSUB_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout_borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG = seg_width(WIDTH, STAGES);
  localparam int M   = WIDTH - 1;

  stage_t st [STAGES];
  stage_t in0;
  stage_t last;
  logic   adv;
  logic   ovf;
  logic [WIDTH-1:0] res;

  assign last      = st[STAGES-1];
  assign out_valid = last.valid;
  assign adv       = !(out_valid && !out_ready);
  assign in_ready  = adv;

  // Operand b is inverted up front; sub doubles as the initial carry.
  always_comb begin
    in0       = '0;
    in0.valid = in_valid;
    in0.sub   = sub;
    in0.carry = sub;
    in0.a     = ADDSUB_MAX_W'(a);
    in0.b     = ADDSUB_MAX_W'(sub ? ~b : b);
`ifdef ADDSUB_SAT_EN
    in0.sat   = sat;
`else
    in0.sat   = 1'b0;
`endif
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    stage_t src;
    stage_t nxt;
    stage_t q;
    logic [SEG-1:0] sum;
    logic co;

    if (k == 0) begin : g_first
      assign src = in0;
    end else begin : g_next
      assign src = st[k-1];
    end

    addsub_segment #(.SEG(SEG)) u_seg (
      .a    (src.a[k*SEG +: SEG]),
      .b    (src.b[k*SEG +: SEG]),
      .cin  (src.carry),
      .sum  (sum),
      .cout (co)
    );

    always_comb begin
      nxt                   = src;
      nxt.r[k*SEG +: SEG]   = sum;
      nxt.carry             = co;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        q <= '0;
      end else if (adv) begin
        q <= nxt;
      end
    end

    assign st[k] = q;
  end

  always_comb begin
    ovf = last.valid
        && (last.a[M] == last.b[M])
        && (last.r[M] != last.a[M]);
    res = last.r[WIDTH-1:0];
`ifdef ADDSUB_SAT_EN
    // Both operands negative means the sum fell below signed min.
    if (ovf && last.sat) begin
      res = last.a[M] ? {1'b1, {(WIDTH-1){1'b0}}}
                      : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  assign result      = res;
  assign overflow    = ovf;
  assign zero        = last.valid && (res == '0);
  assign cout_borrow = last.valid && (last.carry ^ last.sub);

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed vectors against a queue-based
// arithmetic model of the add/sub pipeline.
module tb_pipelined_addsub;

  localparam int W  = 64;
  localparam int ST = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          sat;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  result;
  logic          cout_borrow;
  logic          overflow;
  logic          zero;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .sub         (sub),
`ifdef ADDSUB_SAT_EN
    .sat         (sat),
`endif
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .cout_borrow (cout_borrow),
    .overflow    (overflow),
    .zero        (zero)
  );

  typedef struct {
    logic [W-1:0] r;
    logic         c;
    logic         o;
    logic         z;
    bit           has;
    logic [W-1:0] lr;
    logic         lc;
    logic         lo;
    logic         lz;
    int           idx;
  } item_t;

  item_t q[$];
  int    checks   = 0;
  int    errors   = 0;
  int    advcnt   = 0;
  int    acc_cnt  = 0;
  int    pops     = 0;
  bit    checking = 0;

  bit           lit_has;
  logic [W-1:0] lit_r;
  logic         lit_c;
  logic         lit_o;
  logic         lit_z;

  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] ONES = '1;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Exact-width arithmetic: unsigned sum/diff for carry or borrow,
  // sign-extended sum/diff for overflow and clamp direction.
  function automatic item_t model(input logic [W-1:0] x, y,
                                  input logic s, st);
    item_t it;
    logic [W:0]   u;
    logic [W+1:0] vx, vy, v;
    logic         ov;
    it = '{default: '0};
    u  = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y});
    vx = {{2{x[W-1]}}, x};
    vy = {{2{y[W-1]}}, y};
    v  = s ? (vx - vy) : (vx + vy);
    ov = v[W] != v[W-1];
    it.r = u[W-1:0];
    if (st && ov) it.r = v[W+1] ? SMIN : SMAX;
    it.c = u[W];
    it.o = ov;
    it.z = (it.r == '0);
    return it;
  endfunction

  function automatic bit m_valid();
    return (q.size() != 0) && (q[0].idx + ST == advcnt);
  endfunction

  always @(posedge clk) begin
    item_t it;
    bit v, rdy;
    v   = m_valid();
    rdy = !(v && !out_ready);
    if (!rst_n) begin
      q.delete();
    end else if (rdy) begin
      if (v) begin
        void'(q.pop_front());
        pops++;
      end
      if (in_valid) begin
        it     = model(a, b, sub, sat);
        it.has = lit_has;
        it.lr  = lit_r;
        it.lc  = lit_c;
        it.lo  = lit_o;
        it.lz  = lit_z;
        it.idx = advcnt;
        q.push_back(it);
        acc_cnt++;
      end
      advcnt++;
    end
  end

  always @(posedge clk) begin
    bit mv;
    #1;
    if (checking) begin
      mv = m_valid();
      chk("out_valid", W'(out_valid), W'(mv));
      chk("in_ready", W'(in_ready), W'(!(mv && !out_ready)));
      if (mv) begin
        chk("result", result, q[0].r);
        chk("cout_borrow", W'(cout_borrow), W'(q[0].c));
        chk("overflow", W'(overflow), W'(q[0].o));
        chk("zero", W'(zero), W'(q[0].z));
        if (q[0].has) begin
          chk("lit_result", result, q[0].lr);
          chk("lit_cout", W'(cout_borrow), W'(q[0].lc));
          chk("lit_ovf", W'(overflow), W'(q[0].lo));
          chk("lit_zero", W'(zero), W'(q[0].lz));
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, y, input logic s, st,
                       input bit has, input logic [W-1:0] lr,
                       input logic lc, lo, lz);
    int a0;
    bit ok;
    a0       = acc_cnt;
    ok       = 0;
    a        = x;
    b        = y;
    sub      = s;
    sat      = st;
    lit_has  = has;
    lit_r    = lr;
    lit_c    = lc;
    lit_o    = lo;
    lit_z    = lz;
    in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (acc_cnt != a0) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout actual=0 required=1");
    end
  endtask

  task automatic op(input logic [W-1:0] x, y, input logic s);
    issue(x, y, s, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    lit_has  = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int p0;
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    sat       = 1'b0;
    lit_has   = 1'b0;
    lit_r     = '0;
    lit_c     = 1'b0;
    lit_o     = 1'b0;
    lit_z     = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", W'(out_valid), '0);
    chk("rst_result", result, '0);
    chk("rst_cout", W'(cout_borrow), '0);
    chk("rst_ovf", W'(overflow), '0);
    chk("rst_zero", W'(zero), '0);
    chk("rst_in_ready", W'(in_ready), W'(1));
    rst_n    = 1'b1;
    checking = 1;

    issue(7, 2, 1, 0, 1, 5, 0, 0, 0);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", W'(lat), W'(4));
    idle(4);

    issue(3, ONES - 3, 1, 0, 1, 7, 1, 0, 0);
    issue(ONES - 1, 5, 1, 0, 1, ONES - 6, 0, 0, 0);
    issue(ONES - 7, 1, 1, 0, 1, ONES - 8, 0, 0, 0);
    issue(2, 7, 1, 0, 1, ONES - 4, 1, 0, 0);
    issue(SMIN, 1, 1, 0, 1, SMAX, 0, 1, 0);
    issue(ONES, 1, 0, 0, 1, '0, 1, 0, 1);
    issue(SMIN, SMIN, 0, 0, 1, '0, 1, 1, 1);
    issue(SMAX, 1, 0, 0, 1, SMIN, 0, 1, 0);
`ifdef ADDSUB_SAT_EN
    issue(SMIN, 1, 1, 1, 1, SMIN, 0, 1, 0);
    issue(SMAX, 1, 0, 1, 1, SMAX, 0, 1, 0);
    issue(SMIN, SMIN, 0, 1, 1, SMIN, 1, 1, 0);
`endif
    idle(8);

    p0 = pops;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          op(W'(i) * 64'h0123_4567_89AB + 5,
             W'(i) * 64'h3_0000_0001, i[0]);
        end
        in_valid = 1'b0;
      end
      begin
        logic [W-1:0] he;
        repeat (6) @(negedge clk);
        out_ready = 1'b0;
        he = (q.size() != 0) ? q[0].r : ONES;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          chk("stall_in_ready", W'(in_ready), '0);
          chk("stall_out_valid", W'(out_valid), W'(1));
          chk("stall_hold", result, he);
        end
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk("stall_count", W'(pops - p0), W'(8));

    op(11, 4, 0);
    op(20, 9, 1);
    op(ONES, ONES, 0);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", W'(out_valid), '0);
    chk("mid_rst_ready", W'(in_ready), W'(1));
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("no_stale", W'(seen), '0);

    op(100, 58, 1);
    idle(8);
    chk("drained", W'(q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
